ring_inject_ctrl: RTL and testbench

Upstream feeder for the 8-cell circular shift register. It drives the ring's single-bit inject input from two sources: a debounced push-button that injects exactly one '1' per press, and a parallel pattern loader that serialises an 8-bit word MSB-first. Because the ring shifts left every clock, after a load on a cleared ring the ring holds pattern_in. The block sits between the pad inputs and the ring's data input.

---
 rtl/ring_inject_ctrl.sv | 130 +++++++++++++
 tb/tb_ring_inject_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_inject_ctrl.sv
// Serial feeder for the 8-cell ring: one '1' per debounced button press,
// or an MSB-first serialisation of a parallel pattern on a load request.
`timescale 1ns/1ps

module ring_inject_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PATTERN_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_raw,
  input  logic                 load_req,
  input  logic [PATTERN_W-1:0] pattern_in,
  output logic                 inject_out,
  output logic                 busy,
  output logic                 btn_clean,
  output logic                 overrun
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BIT_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(PATTERN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic                 btn_s1, btn_sync;
  logic                 load_s1, load_s2, load_s3;
  logic                 load_edge, btn_edge;
  logic [CNT_W-1:0]     db_cnt;
  logic                 btn_clean_d;

  state_t               state, state_nx;
  logic [PATTERN_W-1:0] shift_reg, shift_nx;
  logic [BIT_W-1:0]     bit_cnt, cnt_nx;
  logic                 inject_nx, busy_nx, overrun_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 1'b0;
      btn_sync <= 1'b0;
      load_s1  <= 1'b0;
      load_s2  <= 1'b0;
      load_s3  <= 1'b0;
    end else begin
      btn_s1   <= btn_raw;
      btn_sync <= btn_s1;
      load_s1  <= load_req;
      load_s2  <= load_s1;
      load_s3  <= load_s2;
    end
  end

  assign load_edge = load_s2 & ~load_s3;

  // Any cycle where the synchronised level agrees with btn_clean restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      btn_clean_d <= 1'b0;
    end else begin
      btn_clean_d <= btn_clean;
      if (btn_sync != btn_clean) begin
        if (db_cnt == CNT_MAX) begin
          btn_clean <= btn_sync;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign btn_edge = btn_clean & ~btn_clean_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      inject_out <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      shift_reg  <= shift_nx;
      bit_cnt    <= cnt_nx;
      inject_out <= inject_nx;
      busy       <= busy_nx;
      overrun    <= overrun_nx;
    end
  end

  // A load beats a simultaneous press; anything arriving mid-stream is dropped and flagged.
  always_comb begin
    state_nx   = state;
    shift_nx   = shift_reg;
    cnt_nx     = bit_cnt;
    inject_nx  = 1'b0;
    busy_nx    = 1'b0;
    overrun_nx = overrun;
    case (state)
      IDLE: begin
        if (load_edge) begin
          shift_nx = pattern_in;
          cnt_nx   = BIT_TOP;
          state_nx = SHIFT;
          if (btn_edge) overrun_nx = 1'b1;
        end else if (btn_edge) begin
          inject_nx = 1'b1;
        end
      end
      SHIFT: begin
        inject_nx = shift_reg[bit_cnt];
        busy_nx   = 1'b1;
        if (load_edge || btn_edge) overrun_nx = 1'b1;
        if (bit_cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = bit_cnt - BIT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ring_inject_ctrl.sv
// Randomised and directed bench for ring_inject_ctrl, checked every cycle
// against a timing-window model of the debounce, load and conflict rules.
`timescale 1ns/1ps

module tb_ring_inject_ctrl;

  localparam int D  = 16;
  localparam int PW = 8;

  logic          clk;
  logic          rst_n;
  logic          btn_raw;
  logic          load_req;
  logic [PW-1:0] pattern_in;
  logic          inject_out;
  logic          busy;
  logic          btn_clean;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  bit            bhist [0:31];
  bit            lhist [0:3];
  bit            m_clean, m_rose, m_overrun, exp_inj, exp_busy;
  int            cyc, load_n, pulse_cnt;
  logic [PW-1:0] cap, ring;

  ring_inject_ctrl #(.DEBOUNCE_CYCLES(D), .PATTERN_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .load_req   (load_req),
    .pattern_in (pattern_in),
    .inject_out (inject_out),
    .busy       (busy),
    .btn_clean  (btn_clean),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) bhist[k] = 1'b0;
    for (int k = 0; k < 4; k++) lhist[k] = 1'b0;
    m_clean   = 1'b0;
    m_rose    = 1'b0;
    m_overrun = 1'b0;
    exp_inj   = 1'b0;
    exp_busy  = 1'b0;
    load_n    = -100;
    cap       = '0;
    ring      = '0;
  endtask

  // Button: btn_clean flips once the raw level seen at the pads has opposed it for D
  // consecutive samples (two synchroniser cycles earlier). Load: edge lags the pad by 2.
  task automatic model_step();
    bit ld_edge, bt_edge, flip;
    cyc++;
    for (int k = 31; k > 0; k--) bhist[k] = bhist[k-1];
    bhist[0] = btn_raw;
    for (int k = 3; k > 0; k--) lhist[k] = lhist[k-1];
    lhist[0] = load_req;
    ld_edge = lhist[2] & ~lhist[3];
    bt_edge = m_rose;
    flip = 1'b1;
    for (int k = 2; k <= D + 1; k++) if (bhist[k] == m_clean) flip = 1'b0;
    m_rose = flip & ~m_clean;
    if (flip) m_clean = ~m_clean;
    if (cyc > load_n && cyc <= load_n + PW) begin
      if (ld_edge || bt_edge) m_overrun = 1'b1;
      exp_inj  = cap[PW - 1 - (cyc - load_n - 1)];
      exp_busy = 1'b1;
    end else begin
      exp_busy = 1'b0;
      exp_inj  = 1'b0;
      if (ld_edge) begin
        load_n = cyc;
        cap    = pattern_in;
        ring   = '0;
        if (bt_edge) m_overrun = 1'b1;
      end else if (bt_edge) begin
        exp_inj = 1'b1;
      end
    end
  endtask

  initial begin
    cyc       = 0;
    pulse_cnt = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        #1;
        checkOutput("rst_inject", inject_out, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_clean", btn_clean, 0);
        checkOutput("rst_overrun", overrun, 0);
      end else begin
        model_step();
        #1;
        checkOutput("inject", inject_out, exp_inj);
        checkOutput("busy", busy, exp_busy);
        checkOutput("btn_clean", btn_clean, m_clean);
        checkOutput("overrun", overrun, m_overrun);
        if (exp_busy) ring = {ring[PW-2:0], ring[PW-1]} | {{(PW-1){1'b0}}, inject_out};
        if (load_n >= 0 && cyc == load_n + PW) checkOutput("ring", ring, cap);
        if (inject_out === 1'b1 && busy === 1'b0) pulse_cnt++;
      end
    end
  end

  task automatic applyStimulus(input logic b, input logic l, input logic [PW-1:0] p, input int n);
    @(negedge clk);
    btn_raw    = b;
    load_req   = l;
    pattern_in = p;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p0;
    rst_n      = 1'b0;
    btn_raw    = 1'b0;
    load_req   = 1'b0;
    pattern_in = '0;

    for (int i = 0; i < 10; i++) applyStimulus(i[0], ~i[0], PW'($urandom), 1);
    applyStimulus(0, 0, 8'h00, 2);
    rst_n = 1'b1;
    applyStimulus(0, 0, 8'h00, 50);

    p0 = pulse_cnt;
    applyStimulus(1, 0, 8'h00, 40);
    applyStimulus(0, 0, 8'h00, 30);
    checkOutput("press_pulses", pulse_cnt - p0, 1);

    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 8'h00, 5);
      applyStimulus(0, 0, 8'h00, 5);
    end
    applyStimulus(0, 0, 8'h00, 30);
    checkOutput("bounce_pulses", pulse_cnt - p0, 0);
    p0 = pulse_cnt;
    applyStimulus(1, 0, 8'h00, 20);
    applyStimulus(0, 0, 8'h00, 30);
    checkOutput("hold20_pulses", pulse_cnt - p0, 1);

    applyStimulus(0, 1, 8'hA5, 3);
    applyStimulus(0, 0, 8'hA5, 15);
    checkOutput("a5_no_overrun", overrun, 0);

    applyStimulus(0, 1, 8'h96, 4);
    applyStimulus(0, 0, 8'h96, 5);
    applyStimulus(0, 1, 8'h4B, 4);
    applyStimulus(0, 0, 8'h4B, 20);
    checkOutput("b2b_no_overrun", overrun, 0);

    p0 = pulse_cnt;
    applyStimulus(1, 0, 8'h3C, 14);
    applyStimulus(1, 1, 8'h3C, 2);
    applyStimulus(1, 0, 8'h3C, 2);
    applyStimulus(1, 1, 8'hC3, 3);
    applyStimulus(1, 0, 8'h00, 12);
    applyStimulus(0, 0, 8'h00, 30);
    checkOutput("conflict_pulses", pulse_cnt - p0, 0);
    checkOutput("conflict_overrun", overrun, 1);

    applyStimulus(0, 0, 8'hFF, 5);
    applyStimulus(0, 1, 8'hFF, 1);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_inject", inject_out, 0);
    checkOutput("async_busy", busy, 0);
    applyStimulus(0, 0, 8'h00, 3);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    applyStimulus(0, 0, 8'h00, 20);
    checkOutput("post_reset_pulses", pulse_cnt - p0, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    PW'($urandom), $urandom_range(1, 25));
    end
    applyStimulus(0, 0, 8'h00, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
